// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd2bin_state_t;

  // Smallest n with 2**n >= 10**digits; used to validate OUT_W at elaboration.
  function automatic int clog2_pow10(input int digits);
    longint unsigned p;
    int n;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      if ((64'd1 << k) < p) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit correction step of the reverse double-dabble: digits >= 8 lose 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Modulo-16 subtract keeps the digit inside its 4-bit field.
  always_comb begin
    dout = din;
    if (din >= 4'd8) dout = din - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one conversion
// in flight, valid/ready handshakes on input and output.
// Optional build macro BCD_TO_BIN_CHECK_EN adds the bcd_err port and rejects
// non-BCD digits at accept time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// SHIFT | one shift/adjust iteration per cycle, OUT_W cycles total
// DONE  | binaryNum presented with out_valid until out_ready
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OUT_W  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcdNum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              binaryNum,
  output logic                          busy
`ifdef BCD_TO_BIN_CHECK_EN
  ,
  output logic                          bcd_err
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  // OUT_W doubles as the iteration count, so a wrong value silently corrupts results.
  if (OUT_W != clog2_pow10(DIGITS)) begin : g_out_w_check
    $fatal(1, "bcd_to_bin: OUT_W must equal ceil(log2(10**DIGITS))");
  end

  bcd2bin_state_t state, state_next;

  logic [BCD_W-1:0] bcd_reg;
  logic [OUT_W-1:0] bin_reg;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] shift_bcd;
  logic [OUT_W-1:0] shift_bin;
  logic [BCD_W-1:0] adj_bcd;

  logic accept;
  logic digit_bad;

  // Right shift of {bcd_reg, bin_reg}; the BCD LSB drops into the binary MSB.
  always_comb begin
    shift_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
    shift_bin = {bcd_reg[0], bin_reg[OUT_W-1:1]};
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shift_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_CHECK_EN
  // Flag any input digit above 9 so the conversion can be short-circuited.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdNum[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) digit_bad = 1'b1;
    end
  end
`else
  assign digit_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = digit_bad ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load at accept, iterate in SHIFT, hold in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
    end else if (accept) begin
      bcd_reg <= bcdNum;
      bin_reg <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bcd_reg <= adj_bcd;
      bin_reg <= shift_bin;
      cnt     <= cnt + 1'b1;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  // Error flag set at accept, cleared by the output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             bcd_err <= 1'b0;
    else if (accept)                       bcd_err <= digit_bad;
    else if (state == DONE && out_ready)   bcd_err <= 1'b0;
  end
`endif

  // Result is only driven while it is valid; zero otherwise.
  always_comb begin
    binaryNum = out_valid ? bin_reg : '0;
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed table, full sweep, random
// conversions with output stalls, and hand-written hold/reset/error sequences.
module tb_bcd_to_bin;

  localparam int DIGITS = 2;
  localparam int OUT_W  = 7;
  localparam int LAT    = OUT_W + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [4*DIGITS-1:0] bcdNum;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   binaryNum;
  logic               busy;
`ifdef BCD_TO_BIN_CHECK_EN
  logic               bcd_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcdNum    (bcdNum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binaryNum (binaryNum),
    .busy      (busy)
`ifdef BCD_TO_BIN_CHECK_EN
    ,
    .bcd_err   (bcd_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    int         exp_val;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: the value a pair of decimal digits denotes.
  function automatic int ref_value(input int t, input int o);
    return 10 * t + o;
  endfunction

  // One full conversion: accept, wait for result (bounded), optional stall, handshake.
  task automatic convert(input logic [3:0] t, input logic [3:0] o, input int stall,
                         output int res, output int lat);
    int irdy_bad, busy_bad, hold_bad;
    out_ready = (stall == 0);
    bcdNum    = {t, o};
    in_valid  = 1'b1;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcdNum   = 8'($urandom);
    lat      = 1;
    irdy_bad = 0;
    busy_bad = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) irdy_bad++;
      if (!busy)    busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("result_timeout", int'(lat < 50), 1);
    check("in_ready_low_while_busy", irdy_bad, 0);
    check("busy_during_shift", busy_bad, 0);
    res = int'(binaryNum);
`ifdef BCD_TO_BIN_CHECK_EN
    check("bcd_err_clean", int'(bcd_err), 0);
`endif
    hold_bad = 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || int'(binaryNum) != res) hold_bad++;
    end
    if (stall > 0) check("stall_hold", hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_return", int'(in_ready), 1);
  endtask

  initial begin
    int res, lat, t, o, stall, bad;

    vecs[0] = '{4'd3, 4'd1, 31};
    vecs[1] = '{4'd0, 4'd0, 0};
    vecs[2] = '{4'd9, 4'd9, 99};
    vecs[3] = '{4'd1, 4'd0, 10};
    vecs[4] = '{4'd0, 4'd9, 9};
    vecs[5] = '{4'd8, 4'd7, 87};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcdNum    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_binaryNum", int'(binaryNum), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table, including zero and maximum.
    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].tens, vecs[i].ones, 0, res, lat);
      check($sformatf("vec%0d_value", i), res, vecs[i].exp_val);
      check($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Full sweep 00..99.
    bad = 0;
    for (int v = 0; v < 100; v++) begin
      convert(4'(v / 10), 4'(v % 10), 0, res, lat);
      if (res != ref_value(v / 10, v % 10) || lat != LAT) bad++;
    end
    check("sweep_mismatches", bad, 0);

    // Random digits with random output stalls.
    for (int i = 0; i < 40; i++) begin
      t     = $urandom_range(9, 0);
      o     = $urandom_range(9, 0);
      stall = $urandom_range(3, 0);
      convert(4'(t), 4'(o), stall, res, lat);
      check("rand_value", res, ref_value(t, o));
      check("rand_latency", lat, LAT);
    end

    // Hold in DONE with out_ready low while a second input is offered.
    out_ready = 1'b0;
    bcdNum    = {4'd2, 4'd5};
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_latency", lat, LAT);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      bcdNum   = {4'd7, 4'd7};
      in_valid = c[0];
      @(posedge clk); #1;
      if (!out_valid || in_ready || int'(binaryNum) != 25) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_value", int'(binaryNum), 25);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_out_valid", int'(out_valid), 0);
    check("hold_release_in_ready", int'(in_ready), 1);
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("ignored_input_not_queued", bad, 0);

    // Reset in the middle of SHIFT aborts the conversion.
    bcdNum   = {4'd1, 4'd9};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_binaryNum", int'(binaryNum), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", int'(out_valid), 0);
    convert(4'd1, 4'd2, 0, res, lat);
    check("post_abort_value", res, 12);
    check("post_abort_latency", lat, LAT);

`ifdef BCD_TO_BIN_CHECK_EN
    // Non-BCD digit is rejected immediately.
    out_ready = 1'b0;
    bcdNum    = {4'hA, 4'd3};
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("err_out_valid", int'(out_valid), 1);
    check("err_binaryNum", int'(binaryNum), 0);
    check("err_flag", int'(bcd_err), 1);
    @(posedge clk); #1;
    check("err_hold", int'(bcd_err), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("err_clear", int'(bcd_err), 0);
    check("err_in_ready", int'(in_ready), 1);
    convert(4'd4, 4'd2, 0, res, lat);
    check("after_err_value", res, 42);
    check("after_err_latency", lat, LAT);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
